// File: rtl/forwarding_unit_2_reg_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
//   Shared definitions for the store-path forwarding detector.
//   REG_ADDR_W : default width of a register index field.
//   reg_idx_t  : register index type.
//   idx_is_zero: true when an index names the hard-wired zero register.
// ---------------------------------------------------------------------------
package fwd_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    function automatic logic idx_is_zero(input reg_idx_t idx);
        return (idx == '0);
    endfunction

endpackage

// File: rtl/forwarding_unit_2_reg_if.sv
// ---------------------------------------------------------------------------
// forwarding_unit_2_reg_if
//   Bundles the pipeline-register fields that the forwarding detector
//   observes, together with the two operand-select flags it returns.
//   master : pipeline side. It drives the indices and enables, and it
//            receives Sel_A and Sel_B.
//   slave  : detector side. It receives the indices and enables, and it
//            drives Sel_A and Sel_B.
// ---------------------------------------------------------------------------
interface forwarding_unit_2_reg_if #(
    parameter int unsigned REG_ADDR_W = fwd_pkg::REG_ADDR_W
);

    logic                  EX_MEM_MemWrite;
    logic                  MEM_WB_RegWrite;
    logic [REG_ADDR_W-1:0] ID_EX_Rs1;
    logic [REG_ADDR_W-1:0] ID_EX_Rs2;
    logic [REG_ADDR_W-1:0] EX_MEM_Rd;
    logic                  Sel_A;
    logic                  Sel_B;

    modport master (
        output EX_MEM_MemWrite,
        output MEM_WB_RegWrite,
        output ID_EX_Rs1,
        output ID_EX_Rs2,
        output EX_MEM_Rd,
        input  Sel_A,
        input  Sel_B
    );

    modport slave (
        input  EX_MEM_MemWrite,
        input  MEM_WB_RegWrite,
        input  ID_EX_Rs1,
        input  ID_EX_Rs2,
        input  EX_MEM_Rd,
        output Sel_A,
        output Sel_B
    );

endinterface

// File: rtl/forwarding_unit_2_reg_match.sv
// ---------------------------------------------------------------------------
// fwd_match
//   Single-operand index comparator.
//   src : source register index of the younger instruction.
//   dst : destination register index of the older instruction.
//   en  : qualified enable. It already includes the zero-register guard.
//   hit : en and an exact full-width match of src and dst.
// ---------------------------------------------------------------------------
module fwd_match #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] src,
    input  logic [W-1:0] dst,
    input  logic         en,
    output logic         hit
);

    logic w_eq;

    assign w_eq = (src == dst);
    assign hit  = en & w_eq;

endmodule

// File: rtl/forwarding_unit_2_reg.sv
// ---------------------------------------------------------------------------
// forwarding_unit_2_reg
//   Store-path forwarding detector. When the EX/MEM instruction is a store
//   and the register-write qualifier is set, each ID/EX source index is
//   compared against the EX/MEM destination index. The per-operand select
//   flags are registered, so they appear one cycle after the inputs.
//   clk   : pipeline clock, rising-edge active.
//   reset : asynchronous, active-high. Clears both select flops.
//   bus   : slave side of forwarding_unit_2_reg_if. It carries
//           EX_MEM_MemWrite, MEM_WB_RegWrite, ID_EX_Rs1, ID_EX_Rs2 and
//           EX_MEM_Rd in, and Sel_A and Sel_B out.
// Parameters:
//   REG_ADDR_W     : register index width.
//   ZERO_REG_GUARD : when set, destination index 0 never forwards.
// ---------------------------------------------------------------------------
module forwarding_unit_2_reg #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter bit          ZERO_REG_GUARD = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    forwarding_unit_2_reg_if.slave        bus
);

    import fwd_pkg::*;

    logic w_en;
    logic w_nz;
    logic w_fwd_en;
    logic w_hit_a;
    logic w_hit_b;
    logic r_sel_a;
    logic r_sel_b;

    assign w_en = bus.EX_MEM_MemWrite & bus.MEM_WB_RegWrite;

    // x0 is hard-wired. A write to x0 must never be treated as a producer.
    always_comb begin
        w_nz = 1'b1;
        if (ZERO_REG_GUARD)
            w_nz = (bus.EX_MEM_Rd != '0);
    end

    // The zero guard is shared by both operands, so it is folded into the
    // enable once instead of being repeated in each comparator.
    assign w_fwd_en = w_en & w_nz;

    fwd_match #(.W(REG_ADDR_W)) u_match_rs1 (
        .src (bus.ID_EX_Rs1),
        .dst (bus.EX_MEM_Rd),
        .en  (w_fwd_en),
        .hit (w_hit_a)
    );

    fwd_match #(.W(REG_ADDR_W)) u_match_rs2 (
        .src (bus.ID_EX_Rs2),
        .dst (bus.EX_MEM_Rd),
        .en  (w_fwd_en),
        .hit (w_hit_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_a <= 1'b0;
            r_sel_b <= 1'b0;
        end else begin
            r_sel_a <= w_hit_a;
            r_sel_b <= w_hit_b;
        end
    end

    assign bus.Sel_A = r_sel_a;
    assign bus.Sel_B = r_sel_b;

endmodule

// File: tb/tb_forwarding_unit_2_reg.sv
module tb_forwarding_unit_2_reg;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    forwarding_unit_2_reg_if #(.REG_ADDR_W(5)) bus ();

    forwarding_unit_2_reg #(
        .REG_ADDR_W     (5),
        .ZERO_REG_GUARD (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] sel;   // {Sel_A, Sel_B}
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference rules: forward only for a store whose write is qualified,
    // never from register 0, and each operand independently on index equality.
    function automatic logic [1:0] model(input logic mw, input logic rw,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd);
        logic a, b;
        if (!(mw && rw) || rd == 0)
            return 2'b00;
        a = (rs1 == rd);
        b = (rs2 == rd);
        return {a, b};
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {Sel_A,Sel_B}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mw, input logic rw,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.EX_MEM_MemWrite = mw;
        bus.MEM_WB_RegWrite = rw;
        bus.ID_EX_Rs1       = rs1;
        bus.ID_EX_Rs2       = rs2;
        bus.EX_MEM_Rd       = rd;
    endtask

    // Inputs change 2 time units after an edge. The expectation applies to the
    // outputs after the following edge.
    task automatic apply(input logic mw, input logic rw,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input string tag);
        exp_t e;
        @(posedge clk);
        #2;
        drive(mw, rw, rs1, rs2, rd);
        e.sel = model(mw, rw, rs1, rs2, rd);
        e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: the outputs are valid every cycle, so an expectation is popped
    // whenever one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.tag, {bus.Sel_A, bus.Sel_B}, e.sel);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected completion", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic mw, rw;
        logic [4:0] rs1, rs2, rd;

        // Reset is held while the inputs would produce a double match.
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 5'd3, 5'd3);
        #1;
        check("reset_initial", {bus.Sel_A, bus.Sel_B}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {bus.Sel_A, bus.Sel_B}, 2'b00);

        // Release reset. The first edge afterwards loads the held inputs.
        @(posedge clk);
        #2;
        reset = 1'b0;
        e.sel = model(1'b1, 1'b1, 5'd3, 5'd3, 5'd3);
        e.tag = "post_reset_load";
        q.push_back(e);

        // Directed cases.
        apply(1'b1, 1'b1, 5'd1, 5'd0, 5'd1, "rs1_match");
        apply(1'b1, 1'b1, 5'd0, 5'd1, 5'd1, "rs2_match");
        apply(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, "regwrite_off");
        apply(1'b0, 1'b1, 5'd1, 5'd0, 5'd1, "memwrite_off");
        apply(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, "double_match");
        apply(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, "zero_guard");
        apply(1'b1, 1'b1, 5'd31, 5'd30, 5'd31, "max_index");
        apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, "pre_mid_reset");

        // Mid-operation reset. The outputs become 11 at the next edge, and
        // the asynchronous reset then clears them without waiting for an edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", {bus.Sel_A, bus.Sel_B}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_mid_hold", {bus.Sel_A, bus.Sel_B}, 2'b00);
        @(posedge clk);
        #2;
        reset = 1'b0;
        e.sel = model(1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
        e.tag = "post_mid_reset_load";
        q.push_back(e);

        // Randomised traffic. Indices are biased toward a small range so that
        // matches are frequent.
        for (int i = 0; i < 300; i++) begin
            mw = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                rs1 = 5'($urandom_range(0, 3));
                rs2 = 5'($urandom_range(0, 3));
                rd  = 5'($urandom_range(0, 3));
            end else begin
                rs1 = 5'($urandom_range(0, 31));
                rs2 = 5'($urandom_range(0, 31));
                rd  = 5'($urandom_range(0, 31));
            end
            apply(mw, rw, rs1, rs2, rd, "random");
        end

        repeat (2) @(posedge clk);
        #3;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
